acc_result_checker: RTL

ACC_RESULT_CHECKER -- requirements
Module: acc_result_checker

---
 rtl/acc_result_checker.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/acc_result_checker.sv
`default_nettype none
// ============================================================================
// Module   : acc_result_checker
// Brief    : Reference MAC accumulator that checks a DUT's job result.
//            Optional CHK_BIAS_EN adds the latched bias to the reference.
// Revision : 1.0 - initial release
// ============================================================================
module acc_result_checker #(
  parameter int CHANNELS = 3,
  parameter int PIXEL_W  = 8,
  parameter int WEIGHT_W = 8,
  parameter int RESULT_W = 32,
  parameter int CNT_W    = 14
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [CNT_W-1:0]             iter_len,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*PIXEL_W-1:0]  pixel_data,
  input  logic [CHANNELS*WEIGHT_W-1:0] weight_data,
  input  logic [15:0]                  bias,
  input  logic                         dut_valid,
  input  logic [RESULT_W-1:0]          dut_result,
  input  logic                         clear_errors,
  output logic                         busy,
  output logic                         done,
  output logic [RESULT_W-1:0]          ref_result,
  output logic                         match,
  output logic                         cat_out,
  output logic [15:0]                  mismatch_cnt,
  output logic                         error_sticky
);

  localparam int c_PROD_W = PIXEL_W + WEIGHT_W + 1;
  localparam int c_SUM_W  = PIXEL_W + WEIGHT_W + 4;
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [15:0]      c_CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCUM    = 2'd1,
    FINAL    = 2'd2,
    WAIT_DUT = 2'd3
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_iter_len;
  logic [CNT_W-1:0]      r_beat_cnt;
  logic [RESULT_W-1:0]   r_acc;
  logic [RESULT_W-1:0]   r_ref_result;
  logic [15:0]           r_mismatch_cnt;
  logic                  r_in_ready;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_match;
  logic                  r_cat_out;
  logic                  r_error_sticky;

  logic signed [c_PROD_W-1:0] w_prod [CHANNELS];
  logic [c_SUM_W-1:0]         w_beat_sum;
  logic [RESULT_W-1:0]        w_beat_ext;
  logic [RESULT_W-1:0]        w_acc_next;
  logic [RESULT_W-1:0]        w_final_val;
  logic                       w_final_pos;
  logic                       w_accept;
  logic                       w_last_beat;
  logic                       w_ovf;
  logic                       w_ovf_evt;
  logic                       w_eq;
  logic                       w_mismatch;

  // Pixel is zero-extended, weight sign-extended, so the product is a plain
  // signed multiply at full product width.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    logic [PIXEL_W-1:0]  w_pix;
    logic [WEIGHT_W-1:0] w_wt;
    assign w_pix     = pixel_data[k*PIXEL_W +: PIXEL_W];
    assign w_wt      = weight_data[k*WEIGHT_W +: WEIGHT_W];
    assign w_prod[k] = $signed({{(WEIGHT_W+1){1'b0}}, w_pix})
                     * $signed({{(PIXEL_W+1){w_wt[WEIGHT_W-1]}}, w_wt});
  end

  always_comb begin
    w_beat_sum = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_beat_sum = w_beat_sum
                 + {{(c_SUM_W-c_PROD_W){w_prod[k][c_PROD_W-1]}}, w_prod[k]};
    end
  end

  if (RESULT_W > c_SUM_W) begin : g_sum_ext
    assign w_beat_ext = {{(RESULT_W-c_SUM_W){w_beat_sum[c_SUM_W-1]}}, w_beat_sum};
  end else begin : g_sum_noext
    assign w_beat_ext = w_beat_sum;
  end

  assign w_acc_next = r_acc + w_beat_ext;
  // Signed overflow: operands agree in sign but the sum does not.
  assign w_ovf = (r_acc[RESULT_W-1] == w_beat_ext[RESULT_W-1])
              && (w_acc_next[RESULT_W-1] != r_acc[RESULT_W-1]);

  assign w_accept    = (r_state == ACCUM) && in_valid && r_in_ready;
  assign w_last_beat = ((r_beat_cnt + c_CNT_ONE) == r_iter_len);
  assign w_ovf_evt   = w_accept && w_ovf;
  assign w_eq        = (dut_result == r_ref_result);
  assign w_mismatch  = (r_state == WAIT_DUT) && dut_valid && !w_eq;

`ifdef CHK_BIAS_EN
  logic [15:0]         r_bias;
  logic [RESULT_W-1:0] w_bias_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bias <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_bias <= bias;
    end
  end

  if (RESULT_W > 16) begin : g_bias_ext
    assign w_bias_ext = {{(RESULT_W-16){r_bias[15]}}, r_bias};
  end else begin : g_bias_trunc
    assign w_bias_ext = r_bias[RESULT_W-1:0];
  end

  assign w_final_val = r_acc + w_bias_ext;
`else
  logic w_unused_bias;
  assign w_unused_bias = ^bias;
  assign w_final_val   = r_acc;
`endif

  assign w_final_pos = !w_final_val[RESULT_W-1] && (|w_final_val);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_iter_len     <= '0;
      r_beat_cnt     <= '0;
      r_acc          <= '0;
      r_ref_result   <= '0;
      r_mismatch_cnt <= '0;
      r_in_ready     <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_match        <= 1'b0;
      r_cat_out      <= 1'b0;
      r_error_sticky <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_iter_len <= iter_len;
            r_acc      <= '0;
            r_beat_cnt <= '0;
            r_busy     <= 1'b1;
            if (iter_len == '0) begin
              r_state <= FINAL;
            end else begin
              r_state    <= ACCUM;
              r_in_ready <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (w_accept) begin
            r_acc      <= w_acc_next;
            r_beat_cnt <= r_beat_cnt + c_CNT_ONE;
            if (w_last_beat) begin
              r_state    <= FINAL;
              r_in_ready <= 1'b0;
            end
          end
        end
        FINAL: begin
          r_ref_result <= w_final_val;
          r_cat_out    <= w_final_pos;
          r_state      <= WAIT_DUT;
        end
        WAIT_DUT: begin
          if (dut_valid) begin
            r_match <= w_eq;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase

      // A same-cycle clear outranks any new error event.
      if (clear_errors) begin
        r_mismatch_cnt <= '0;
        r_error_sticky <= 1'b0;
      end else begin
        if (w_mismatch && (r_mismatch_cnt != c_CNT_MAX)) begin
          r_mismatch_cnt <= r_mismatch_cnt + 16'd1;
        end
        if (w_mismatch || w_ovf_evt) begin
          r_error_sticky <= 1'b1;
        end
      end
    end
  end

  assign in_ready     = r_in_ready;
  assign busy         = r_busy;
  assign done         = r_done;
  assign ref_result   = r_ref_result;
  assign match        = r_match;
  assign cat_out      = r_cat_out;
  assign mismatch_cnt = r_mismatch_cnt;
  assign error_sticky = r_error_sticky;

endmodule
`default_nettype wire
